// File: rtl/ebpc_stream_interleaver.sv
// ebpc_stream_interleaver: burst round-robin merge of the BPC (A) and ZNZ (B) streams onto one registered output
module ebpc_stream_interleaver #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_last_i,
    input  logic              a_vld_i,
    output logic              a_rdy_o,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              b_last_i,
    input  logic              b_vld_i,
    output logic              b_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              src_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              idle_o
);
    typedef enum logic [1:0] {SERVE_A, SERVE_B, DRAIN_A, DRAIN_B} state_t;
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic a_done, b_done, a_done_n, b_done_n;
    logic load_en, grant_a, hs, in_last, draining;
    assign load_en  = !vld_o || rdy_i;
    assign grant_a  = state == SERVE_A || state == DRAIN_A;
    assign draining = state == DRAIN_A || state == DRAIN_B;
    assign a_rdy_o  = load_en && grant_a;
    assign b_rdy_o  = load_en && !grant_a;
    assign hs       = grant_a ? a_vld_i && a_rdy_o : b_vld_i && b_rdy_o;
    assign in_last  = grant_a ? a_last_i : b_last_i;
    assign idle_o   = state == SERVE_A && cnt == '0 && !a_done && !b_done && !vld_o;
    always_comb begin
        state_n  = state;
        a_done_n = a_done;
        b_done_n = b_done;
        if (hs) begin
            case (state)
                SERVE_A: begin
                    if (a_last_i) begin
                        state_n  = DRAIN_B;
                        a_done_n = 1'b1;
                    end else if (cnt == CNT_MAX) state_n = SERVE_B;
                end
                SERVE_B: begin
                    if (b_last_i) begin
                        state_n  = DRAIN_A;
                        b_done_n = 1'b1;
                    end else if (cnt == CNT_MAX) state_n = SERVE_A;
                end
                default: begin
                    if (in_last) begin
                        state_n  = SERVE_A;
                        a_done_n = 1'b0;
                        b_done_n = 1'b0;
                    end
                end
            endcase
        end
        cnt_n = state_n != state ? '0 : hs && !draining ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= SERVE_A;
            cnt    <= '0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            vld_o  <= 1'b0;
            data_o <= '0;
            src_o  <= 1'b0;
            last_o <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            a_done <= a_done_n;
            b_done <= b_done_n;
            if (load_en) vld_o <= hs;
            if (hs) begin
                data_o <= grant_a ? a_data_i : b_data_i;
                src_o  <= !grant_a;
                last_o <= in_last && draining;
            end
        end
    end
    // a stream that already delivered its last word must not deliver another within the frame
    assert property (@(posedge clk_i) disable iff (!rst_ni) a_vld_i && a_rdy_o && a_last_i |-> !a_done);
    assert property (@(posedge clk_i) disable iff (!rst_ni) b_vld_i && b_rdy_o && b_last_i |-> !b_done);
    assert property (@(posedge clk_i) disable iff (!rst_ni) a_vld_i && !a_rdy_o |=> $stable(a_data_i))
        else $warning("a_data_i changed while stalled");
    assert property (@(posedge clk_i) disable iff (!rst_ni) b_vld_i && !b_rdy_o |=> $stable(b_data_i))
        else $warning("b_data_i changed while stalled");
endmodule

// File: tb/tb_ebpc_stream_interleaver.sv
// tb_ebpc_stream_interleaver: directed frames with a queued scoreboard checked by an output monitor
module tb_ebpc_stream_interleaver;
    logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic [7:0] a_data = '0, b_data = '0;
    logic a_last = 1'b0, b_last = 1'b0, a_vld = 1'b0, b_vld = 1'b0, rdy = 1'b1;
    logic a_rdy0, b_rdy0, src0, last0, vld0, idle0, a_rdy1, b_rdy1, src1, last1, vld1, idle1;
    logic [7:0] data0, data1, data;
    logic a_rdy, b_rdy, src, last, vld, idle;
    int checks = 0, errors = 0, cyc = 0, a_cnt = 0, b_cnt = 0, first_a_hs = 0, ph = 0;
    logic [9:0] exp_q[$];
    int cyc_q[$];
    logic [8:0] a_words[$], b_words[$];
    logic rdy_pat = 1'b0, hold_v = 1'b0;
    logic [9:0] hold_w = '0;
    logic [3:0] pat = 4'b1001;
    logic [9:0] t1 [12] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h120, 10'h121,
                            10'h122, 10'h123, 10'h014, 10'h015, 10'h124, 10'h325};
    logic [9:0] t2 [13] = '{10'h030, 10'h031, 10'h140, 10'h141, 10'h142, 10'h143, 10'h144,
                            10'h145, 10'h146, 10'h147, 10'h348, 10'h050, 10'h360};
    logic [9:0] t4 [9]  = '{10'h070, 10'h071, 10'h072, 10'h073, 10'h180, 10'h181, 10'h182, 10'h183, 10'h274};
    logic [9:0] t5 [6]  = '{10'h0A0, 10'h0A1, 10'h0A2, 10'h0A3, 10'h1B0, 10'h2A4};
    logic [9:0] t6 [8]  = '{10'h0C0, 10'h1D0, 10'h1D1, 10'h3D2, 10'h0E0, 10'h1F0, 10'h0E1, 10'h3F1};

    always #5 clk = ~clk;

    ebpc_stream_interleaver #(.DATA_W(8), .BURST_LEN(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_data_i(a_data), .a_last_i(a_last), .a_vld_i(a_vld && !sel), .a_rdy_o(a_rdy0),
        .b_data_i(b_data), .b_last_i(b_last), .b_vld_i(b_vld && !sel), .b_rdy_o(b_rdy0),
        .data_o(data0), .src_o(src0), .last_o(last0), .vld_o(vld0), .rdy_i(rdy), .idle_o(idle0));
    ebpc_stream_interleaver #(.DATA_W(8), .BURST_LEN(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_data_i(a_data), .a_last_i(a_last), .a_vld_i(a_vld && sel), .a_rdy_o(a_rdy1),
        .b_data_i(b_data), .b_last_i(b_last), .b_vld_i(b_vld && sel), .b_rdy_o(b_rdy1),
        .data_o(data1), .src_o(src1), .last_o(last1), .vld_o(vld1), .rdy_i(rdy), .idle_o(idle1));

    assign a_rdy = sel ? a_rdy1 : a_rdy0;
    assign b_rdy = sel ? b_rdy1 : b_rdy0;
    assign data  = sel ? data1 : data0;
    assign src   = sel ? src1 : src0;
    assign last  = sel ? last1 : last0;
    assign vld   = sel ? vld1 : vld0;
    assign idle  = sel ? idle1 : idle0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit is_b);
        int n;
        int sz = is_b ? b_words.size() : a_words.size();
        @(posedge clk);
        #1;
        for (int i = 0; i < sz; i++) begin
            logic [8:0] w;
            w = is_b ? b_words[i] : a_words[i];
            if (is_b) begin b_data = w[7:0]; b_last = w[8]; b_vld = 1'b1; end
            else begin a_data = w[7:0]; a_last = w[8]; a_vld = 1'b1; end
            n = 0;
            do begin @(negedge clk); n++; end while (!(is_b ? b_rdy : a_rdy) && n < 500);
            if (!(is_b ? b_rdy : a_rdy)) chk(is_b ? "b_accept_timeout" : "a_accept_timeout", 32'(is_b ? b_rdy : a_rdy), 1);
            if (!is_b && a_cnt == 0) first_a_hs = cyc;
            @(posedge clk);
            #1;
            if (is_b) b_cnt++; else a_cnt++;
        end
        if (is_b) b_vld = 1'b0; else a_vld = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); n++; end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rdy = rdy_pat ? pat[ph] : 1'b1;
        ph = (ph + 1) % 4;
    end

    // output monitor: scoreboard pop on every transfer, hold check on every stall
    always @(negedge clk) begin
        if (hold_v && rst_n) chk("stall_hold", {vld, last, src, data}, {1'b1, hold_w});
        hold_v = rst_n && vld && !rdy;
        hold_w = {last, src, data};
        if (rst_n && vld && rdy) begin
            cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0h expected none", {last, src, data});
            end else chk("out_word", {last, src, data}, exp_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", vld, 0);
        chk("rst_last", last, 0);
        chk("rst_src", src, 0);
        chk("rst_data", data, 0);
        chk("rst_idle", idle, 1);
        rst_n = 1'b1;
        // burst alternation with an uneven tail
        a_words = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h115};
        b_words = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h024, 9'h125};
        foreach (t1[i]) exp_q.push_back(t1[i]);
        cyc_q.delete(); a_cnt = 0; b_cnt = 0;
        fork drive(0); drive(1); join
        wait_empty();
        chk("first_out_latency", cyc_q.size() > 0 ? cyc_q[0] - first_a_hs : -1, 1);
        @(negedge clk);
        chk("idle_after_frame", idle, 1);
        chk("vld_after_frame", vld, 0);
        // A finishes early, B drains; then a back-to-back second frame
        a_words = '{9'h030, 9'h131, 9'h150};
        b_words = '{9'h040, 9'h041, 9'h042, 9'h043, 9'h044, 9'h045, 9'h046, 9'h047, 9'h148, 9'h160};
        foreach (t2[i]) exp_q.push_back(t2[i]);
        a_cnt = 0; b_cnt = 0;
        fork
            drive(0);
            drive(1);
            begin
                int n = 0;
                wait (a_cnt >= 2);
                while (b_cnt < 9 && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (b_cnt < 9) chk("drain_a_rdy", a_rdy, 0);
                end
            end
        join
        wait_empty();
        // downstream backpressure 1,0,0,1
        a_words = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h115};
        b_words = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h024, 9'h125};
        foreach (t1[i]) exp_q.push_back(t1[i]);
        a_cnt = 0; b_cnt = 0;
        rdy_pat = 1'b1;
        fork drive(0); drive(1); join
        wait_empty();
        rdy_pat = 1'b0;
        // B withholds data on its turn while A waits
        a_words = '{9'h070, 9'h071, 9'h072, 9'h073, 9'h174};
        b_words = '{9'h080, 9'h081, 9'h082, 9'h183};
        foreach (t4[i]) exp_q.push_back(t4[i]);
        a_cnt = 0; b_cnt = 0;
        fork
            drive(0);
            begin
                wait (a_cnt >= 4);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("b_gap_a_rdy", a_rdy, 0);
                    if (i > 0) chk("b_gap_no_out", vld, 0);
                end
                drive(1);
            end
        join
        wait_empty();
        // asynchronous reset with a word held in the output register
        a_words = '{9'h090, 9'h091, 9'h092};
        exp_q.push_back(10'h090);
        exp_q.push_back(10'h091);
        a_cnt = 0;
        drive(0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_vld", vld, 0);
        chk("async_rst_data", data, 0);
        chk("async_rst_idle", idle, 1);
        chk("pre_rst_words", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        a_words = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
        b_words = '{9'h1B0};
        foreach (t5[i]) exp_q.push_back(t5[i]);
        a_cnt = 0; b_cnt = 0;
        fork drive(0); drive(1); join
        wait_empty();
        // single-word bursts, back-to-back frames
        @(posedge clk);
        #1 rst_n = 1'b0;
        sel = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("bl1_idle", idle, 1);
        a_words = '{9'h1C0, 9'h0E0, 9'h1E1};
        b_words = '{9'h0D0, 9'h0D1, 9'h1D2, 9'h0F0, 9'h1F1};
        foreach (t6[i]) exp_q.push_back(t6[i]);
        cyc_q.delete(); a_cnt = 0; b_cnt = 0;
        fork drive(0); drive(1); join
        wait_empty();
        chk("no_bubble_between_frames", cyc_q.size() > 4 ? cyc_q[4] - cyc_q[3] : -1, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ebpc_stream_interleaver.md
Name: ebpc_stream_interleaver

Overview:
- Merges the two encoder output streams onto one DATA_W output bus: stream A is the BPC stream from the bit-plane/sequence coder, stream B is the zero/non-zero (ZNZ) stream.
- Arbitration is a deterministic burst round-robin of fixed BURST_LEN words, so the decoder can de-interleave without header words.
- Sits between the two coders and the top-level encoder output.
- Registered output stage with full throughput.

Parameters:
- DATA_W, ebpc_pkg::DATA_W (8), word width of all data buses.
- BURST_LEN, 4, words taken from one stream before switching; legal range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- a_data_i  in  DATA_W  BPC stream word.
- a_last_i  in  1  final word of BPC stream.
- a_vld_i  in  1  BPC word valid.
- a_rdy_o  out  1  BPC word accepted when a_vld_i&&a_rdy_o.
- b_data_i  in  DATA_W  ZNZ stream word.
- b_last_i  in  1  final word of ZNZ stream.
- b_vld_i  in  1  ZNZ word valid.
- b_rdy_o  out  1  ZNZ word accepted when b_vld_i&&b_rdy_o.
- data_o  out  DATA_W  merged word.
- src_o  out  1  source of data_o: 0=A, 1=B.
- last_o  out  1  final word of the merged stream.
- vld_o  out  1  output valid.
- rdy_i  in  1  downstream ready.
- idle_o  out  1  no stream in progress and output register empty.

Behaviour:
- Reset: clk_i rising edge; rst_ni asynchronous, active-low.
  - All state cleared: state=SERVE_A, burst_cnt=0, a_done=b_done=0, output register empty.
  - Outputs: vld_o=0, last_o=0, src_o=0, data_o=0, idle_o=1.
  - A reset asserted mid-operation discards the partial stream and any held output word; no handshake completes during reset.
- Output register: single entry. Loads when empty or when vld_o&&rdy_i in the same cycle (load_en).
  - Latency is 1 cycle from input handshake to vld_o.
  - Sustains 1 word/cycle with rdy_i=1.
  - While vld_o&&!rdy_i, data_o, src_o and last_o hold stable.
- Input ready:
  - a_rdy_o = load_en && (state==SERVE_A || state==DRAIN_A).
  - b_rdy_o = load_en && (state==SERVE_B || state==DRAIN_B).
  - The non-granted stream always sees rdy=0.
  - No skipping: if the granted stream is not valid, the interleaver waits even if the other stream is valid.
- burst_cnt, width clog2(BURST_LEN+1):
  - Increments on each input handshake in SERVE_A/SERVE_B.
  - Resets to 0 on every state change.
  - Unused in DRAIN states.
- FSM states and transitions (on granted handshake):
  - SERVE_A: on a_last_i go to DRAIN_B and set a_done. Otherwise, if burst_cnt==BURST_LEN-1, go to SERVE_B.
  - SERVE_B: on b_last_i go to DRAIN_A and set b_done. Otherwise, if burst_cnt==BURST_LEN-1, go to SERVE_A.
  - DRAIN_A (B finished): accept A words back-to-back. On a_last_i go to SERVE_A and clear both done flags.
  - DRAIN_B (A finished): symmetric; on b_last_i go to SERVE_A and clear both done flags.
  - A last on a burst-boundary word takes the DRAIN transition, not the SERVE switch.
- last_o is set only on the word that completes the second stream to finish. The first stream's own last flag is not forwarded.
- src_o is registered alongside data_o.
- idle_o = (state==SERVE_A) && burst_cnt==0 && !a_done && !b_done && !vld_o.
- Back-to-back frames: after the final word, the next accepted word is from A in the following cycle, with no bubble.
- Assertions:
  - a_last_i/b_last_i must not arrive on a done stream.
  - Input data must stay stable while vld&&!rdy (warning only).

Test Plan:
- A=0x10..0x15 (6 words, last on 0x15), B=0x20..0x25, BURST_LEN=4, rdy_i=1 -> data_o = 10,11,12,13,20,21,22,23,14,15,24,25; src_o = 0000 1111 00 11; last_o only on 0x25; first vld_o 1 cycle after first a handshake; idle_o back to 1 the cycle after 0x25 is accepted.
- A=2 words (last on A1), B=9 words -> A0,A1,B0..B8 contiguous; after A1 the FSM is in DRAIN_B; last_o on B8 only; a_rdy_o=0 throughout the drain.
- Same streams as the first test with rdy_i pattern 1,0,0,1 repeating -> identical 12-word sequence, no loss or duplication; data_o/src_o/last_o stable during stalls; at most one word accepted per rdy_i=1 cycle.
- During B's turn, b_vld_i=0 for 5 cycles while a_vld_i=1 -> a_rdy_o=0 and no output for 5 cycles; resumes with B when b_vld_i rises.
- rst_ni pulsed low after 3 words of A's first burst (one word held in output register) -> vld_o=0 immediately (asynchronously); after release, the next accepted word is from A with burst_cnt=0 and last_o=0.
- BURST_LEN=1, A=1 word (last), B=3 words -> A0,B0,B1,B2, last_o on B2; then a new frame begins with A with no idle cycle.
